// File: rtl/seq_mult_16.sv
// seq_mult_16: multi-cycle 16x16 shift-and-add multiplier.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_mult_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [15:0] mcand;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [16:0] sum;
    logic        ovf_nxt;
    logic        ready;
    logic        last;
    logic        accept;

    assign ready  = (state == IDLE) || (state == DONE);
    assign accept = ready && start;
    assign last   = (cnt == 4'd15);

    // State register plus registered busy/done decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Next-state logic; start is only looked at when ready
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SEQ_MULT_SIGNED_EN
    logic [16:0] hi_x;
    logic [16:0] m_x;
    assign hi_x = {acc[31], acc[31:16]};
    assign m_x  = {mcand[15], mcand};

    // Sign-extended add; the last partial product carries negative weight
    always_comb begin
        sum = hi_x;
        if (acc[0]) begin
            if (last) sum = hi_x + ~m_x + 17'd1;
            else      sum = hi_x + m_x;
        end
        acc_nxt = {sum, acc[15:1]};
        ovf_nxt = (acc_nxt[31:16] != {16{acc_nxt[15]}});
    end
`else
    // Unsigned add with carry-out shifted into bit 31
    always_comb begin
        sum = {1'b0, acc[31:16]};
        if (acc[0]) sum = {1'b0, acc[31:16]} + {1'b0, mcand};
        acc_nxt = {sum, acc[15:1]};
        ovf_nxt = (acc_nxt[31:16] != 16'h0000);
    end
`endif

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            mcand   <= 16'h0000;
            acc     <= 32'h0;
            product <= 32'h0;
            ovf     <= 1'b0;
        end else if (accept) begin
            cnt   <= 4'd0;
            mcand <= a;
            acc   <= {16'h0000, b};
        end else if (state == RUN) begin
            cnt <= cnt + 4'd1;
            acc <= acc_nxt;
            if (last) begin
                product <= acc_nxt;
                ovf     <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_16.sv
// tb_seq_mult_16: table vectors, scoreboard and corner sequences.
// Build with SEQ_MULT_SIGNED_EN to exercise the signed variant.
module tb_seq_mult_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovf;

    seq_mult_16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        o;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic        o;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   ncmp = 0;
    int   nerr = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x,
                                   input logic [15:0] y);
        exp_t e;
`ifdef SEQ_MULT_SIGNED_EN
        e.p = 32'($signed(x) * $signed(y));
        e.o = (e.p[31:16] != {16{e.p[15]}});
`else
        e.p = 32'(x) * 32'(y);
        e.o = (e.p[31:16] != 16'h0000);
`endif
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            check("busy_in_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_done: product %h", product);
            end else begin
                e = sb.pop_front();
                check("product", product, e.p);
                check("ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    // Drive operands with start; caller guarantees the DUT is ready
    task automatic launch(input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] ep, input logic eo);
        exp_t e;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        e.p = ep;
        e.o = eo;
        sb.push_back(e);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic launch_m(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e = model(x, y);
        launch(x, y, e.p, e.o);
    endtask

    // Wait for done with a cycle bound; optionally check timing
    task automatic wait_done(input bit chk);
        int lat;
        int bcnt;
        lat = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        if (!done) begin
            ncmp++;
            nerr++;
            $display("FAIL done_timeout: waited %0d cycles", lat);
        end else if (chk) begin
            check("latency", 32'(lat), 32'd17);
            check("busy_cycles", 32'(bcnt), 32'd16);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_p;
        int          d0;

`ifdef SEQ_MULT_SIGNED_EN
        tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0};
        tbl[2] = '{16'h8000, 16'h8000, 32'h40000000, 1'b1};
        tbl[3] = '{16'hFFFD, 16'h0007, 32'hFFFFFFEB, 1'b0};
        tbl[4] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
        tbl[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1};
        tbl[6] = '{16'h8000, 16'h0001, 32'hFFFF8000, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h8000, 32'h00008000, 1'b1};
`else
        tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
        tbl[2] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
        tbl[3] = '{16'h0002, 16'h0009, 32'h00000012, 1'b0};
        tbl[4] = '{16'h8000, 16'h0002, 32'h00010000, 1'b1};
        tbl[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0};
        tbl[6] = '{16'h0000, 16'hFFFF, 32'h00000000, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", product, 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors, alternating idle starts and back-to-back starts
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].o);
            wait_done(1'b1);
            if (i[0]) repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Start during RUN is ignored; exactly one done follows
        d0 = done_cnt;
        launch(16'd2, 16'd9, 32'h12, 1'b0);
        repeat (5) @(negedge clk);
        a = 16'd0;
        b = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        // Start held in the DONE cycle launches the next op at once
        launch(16'd4, 16'd4, 32'h10, 1'b0);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(1'b0);
        repeat (20) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd2);

        // Asynchronous reset in the middle of an operation
        launch(16'd100, 16'd100, 32'd10000, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_product", product, 32'h0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        launch(16'd10, 16'd10, 32'h64, 1'b0);
        wait_done(1'b1);

        // Product holds while operands toggle with no start
        launch(16'h1234, 16'h0000, 32'h0, 1'b0);
        wait_done(1'b0);
        launch(16'h0003, 16'h0005, 32'hF, 1'b0);
        wait_done(1'b0);
        hold_p = product;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            check("product_hold", product, hold_p);
        end

        // Random operands through the reference model
        for (int i = 0; i < 16; i++) begin
            launch_m(16'($urandom), 16'($urandom));
            wait_done(1'b0);
            if ($urandom_range(1, 0) == 1) repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        if (sb.size() != 0) begin
            ncmp++;
            nerr++;
            $display("FAIL scoreboard_left: %0d entries", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
